// File: rtl/arbiter_rr_decoded.sv
// arbiter_rr_decoded
//   Round-robin arbiter for N = 2**M requesters sharing one resource. The
//   winner's binary index is registered, and the one-hot grant is decoded
//   from it. A grant is held until the owner drops its request, or until the
//   hold watchdog revokes it after MAX_HOLD cycles.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner; search from ptr for the next requester when enabled
//   BUSY    | grant active; only the owner's request and the watchdog matter
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_enable       allows new grants; an active grant is unaffected
//   i_req[N]       level requests; the owner must keep its bit high
//   o_grant_valid  a grant is active
//   o_grant_id[M]  binary index of the owner (last owner while idle)
//   o_grant[N]     one-hot decode of o_grant_id, zero while idle
//   o_timeout      one-cycle pulse when the watchdog revokes a grant
module arbiter_rr_decoded #(
   parameter int M        = 2,
   parameter int N        = 2**M,
   parameter int MAX_HOLD = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_enable,
   input  logic [N-1:0] i_req,
   output logic         o_grant_valid,
   output logic [M-1:0] o_grant_id,
   output logic [N-1:0] o_grant,
   output logic         o_timeout
);

   // With the watchdog disabled the counter is unused; keep one bit so the
   // declaration stays legal.
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [M-1:0]  ptr_q, ptr_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [M-1:0]  grant_id_q, grant_id_d;
   logic          timeout_q, timeout_d;

   logic          found;
   logic [M-1:0]  winner;
   logic [M-1:0]  idx;
   logic          owner_req;

   // Rotating priority search: offsets 0..N-1 from ptr, index wraps mod N
   // through the natural M-bit overflow.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = ptr_q + M'(i);
         if (!found && i_req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign owner_req = i_req[grant_id_q];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      grant_id_d = grant_id_q;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_enable && found) begin
               grant_id_d = winner;
               hold_cnt_d = HW'(1);
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // An owner drop wins over a simultaneous expiry: no timeout pulse.
            if (!owner_req) begin
               state_d    = ST_IDLE;
               ptr_d      = grant_id_q + M'(1);
               hold_cnt_d = '0;
            end else if ((MAX_HOLD > 0) && (hold_cnt_q == HOLD_LIMIT)) begin
               state_d    = ST_IDLE;
               ptr_d      = grant_id_q + M'(1);
               hold_cnt_d = '0;
               timeout_d  = 1'b1;
            end else if (MAX_HOLD > 0) begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         grant_id_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         grant_id_q <= grant_id_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_grant_valid = (state_q == ST_BUSY);
   assign o_grant_id    = grant_id_q;
   assign o_timeout     = timeout_q;

   // Decode of the registered index only, so at most one bit is ever set.
   always_comb begin
      o_grant = '0;
      if (o_grant_valid) o_grant[grant_id_q] = 1'b1;
   end

endmodule

// File: tb/tb_arbiter_rr_decoded.sv
module tb_arbiter_rr_decoded;

   localparam int M        = 2;
   localparam int N        = 4;
   localparam int MAX_HOLD = 8;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic [N-1:0] req;
   logic         grant_valid;
   logic [M-1:0] grant_id;
   logic [N-1:0] grant;
   logic         timeout;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int exp_q[$];

   arbiter_rr_decoded #(.M(M), .MAX_HOLD(MAX_HOLD)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_enable      (enable),
      .i_req         (req),
      .o_grant_valid (grant_valid),
      .o_grant_id    (grant_id),
      .o_grant       (grant),
      .o_timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      req    = '0;
      step();
      step();
      total_cnt++;
      if ({grant_valid, grant_id, grant, timeout} !== '0)
         $display("FAIL reset_outputs: got valid=%b id=%0d grant=%b to=%b, want all 0",
                  grant_valid, grant_id, grant, timeout);
      else pass_cnt++;
      rst_n = 1'b1;
      step();
      total_cnt++;
      if (grant_valid !== 1'b0)
         $display("FAIL reset_idle: got valid=%b, want 0", grant_valid);
      else pass_cnt++;
   endtask

   // ptr is 0 after reset: order 0,1,2,3,0 with one idle cycle between grants
   task automatic test_rotation();
      int order[5] = '{0, 1, 2, 3, 0};
      int e;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(order[k]);
         step();
         e = exp_q.pop_front();
         total_cnt++;
         if (grant_valid !== 1'b1 || grant_id !== M'(e) || grant !== N'(1 << e))
            $display("FAIL rotation_grant%0d: got valid=%b id=%0d grant=%b, want id=%0d",
                     k, grant_valid, grant_id, grant, e);
         else pass_cnt++;
         step();
         req[e] = 1'b0;
         step();
         total_cnt++;
         if (grant_valid !== 1'b0 || grant !== '0 || timeout !== 1'b0)
            $display("FAIL rotation_idle%0d: got valid=%b grant=%b to=%b, want 0/0/0",
                     k, grant_valid, grant, timeout);
         else pass_cnt++;
         if (k < 4) req[e] = 1'b1;
         else req = '0;
      end
   endtask

   task automatic test_single();
      int e;
      req = 4'b0100;
      exp_q.push_back(2);
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (grant_valid !== 1'b1 || grant_id !== M'(e) || grant !== 4'b0100)
         $display("FAIL single_grant: got valid=%b id=%0d grant=%b, want 1/%0d/0100",
                  grant_valid, grant_id, grant, e);
      else pass_cnt++;
      step();
      step();
      total_cnt++;
      if (grant !== 4'b0100)
         $display("FAIL single_hold: got grant=%b, want 0100", grant);
      else pass_cnt++;
      req = '0;
      step();
      total_cnt++;
      if (grant_valid !== 1'b0 || grant !== '0 || grant_id !== 2'd2)
         $display("FAIL single_release: got valid=%b grant=%b id=%0d, want 0/0000/2",
                  grant_valid, grant, grant_id);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int e;
      req = 4'b1000;
      exp_q.push_back(3);
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (grant_valid !== 1'b1 || grant_id !== M'(e))
         $display("FAIL wrap_grant3: got valid=%b id=%0d, want 1/%0d", grant_valid, grant_id, e);
      else pass_cnt++;
      req = '0;
      step();
      req = 4'b0011;
      exp_q.push_back(0);
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (grant_valid !== 1'b1 || grant_id !== M'(e) || grant !== 4'b0001)
         $display("FAIL wrap_grant0: got valid=%b id=%0d grant=%b, want id=%0d",
                  grant_valid, grant_id, grant, e);
      else pass_cnt++;
      req = '0;
      step();
   endtask

   task automatic test_enable();
      int e;
      enable = 1'b0;
      req    = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         step();
         total_cnt++;
         if (grant_valid !== 1'b0 || grant !== '0)
            $display("FAIL enable_off%0d: got valid=%b grant=%b, want 0", k, grant_valid, grant);
         else pass_cnt++;
      end
      enable = 1'b1;
      exp_q.push_back(3);
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (grant_valid !== 1'b1 || grant_id !== M'(e))
         $display("FAIL enable_grant: got valid=%b id=%0d, want 1/%0d", grant_valid, grant_id, e);
      else pass_cnt++;
      enable = 1'b0;
      step();
      step();
      total_cnt++;
      if (grant_valid !== 1'b1 || grant !== 4'b1000)
         $display("FAIL enable_held: got valid=%b grant=%b, want 1/1000", grant_valid, grant);
      else pass_cnt++;
      req = '0;
      step();
      enable = 1'b1;
   endtask

   task automatic test_mid_reset();
      int e;
      req = 4'b0010;
      exp_q.push_back(1);
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (grant_valid !== 1'b1 || grant_id !== M'(e))
         $display("FAIL midrst_grant: got valid=%b id=%0d, want 1/%0d", grant_valid, grant_id, e);
      else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (grant_valid !== 1'b0 || grant !== '0 || grant_id !== '0)
         $display("FAIL midrst_async: got valid=%b grant=%b id=%0d, want 0/0000/0",
                  grant_valid, grant, grant_id);
      else pass_cnt++;
      req = '0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_watchdog();
      int e;
      int held;
      int pulses;
      bit done;
      req = 4'b0011;
      exp_q.push_back(0);
      exp_q.push_back(1);
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (grant_valid !== 1'b1 || grant_id !== M'(e))
         $display("FAIL wd_first: got valid=%b id=%0d, want 1/%0d", grant_valid, grant_id, e);
      else pass_cnt++;
      held   = 1;
      pulses = 0;
      done   = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         step();
         if (timeout === 1'b1) pulses++;
         if (grant_valid === 1'b1) held++;
         else done = 1'b1;
      end
      total_cnt++;
      if (!done || held != MAX_HOLD)
         $display("FAIL wd_hold_len: got %0d cycles (released=%b), want %0d", held, done, MAX_HOLD);
      else pass_cnt++;
      total_cnt++;
      if (timeout !== 1'b1 || grant !== '0 || pulses != 1)
         $display("FAIL wd_pulse: got to=%b grant=%b pulses=%0d, want 1/0000/1",
                  timeout, grant, pulses);
      else pass_cnt++;
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (grant_valid !== 1'b1 || grant_id !== M'(e) || timeout !== 1'b0)
         $display("FAIL wd_next: got valid=%b id=%0d to=%b, want 1/%0d/0",
                  grant_valid, grant_id, timeout, e);
      else pass_cnt++;
      // drop exactly when the watchdog would expire: plain release
      for (int k = 0; k < MAX_HOLD - 1; k++) step();
      total_cnt++;
      if (grant_valid !== 1'b1)
         $display("FAIL wd_tie_held: got valid=%b, want 1", grant_valid);
      else pass_cnt++;
      req = '0;
      step();
      total_cnt++;
      if (grant_valid !== 1'b0 || timeout !== 1'b0)
         $display("FAIL wd_tie_release: got valid=%b to=%b, want 0/0", grant_valid, timeout);
      else pass_cnt++;
      step();
      total_cnt++;
      if (timeout !== 1'b0 || exp_q.size() != 0)
         $display("FAIL wd_final: got to=%b pending=%0d, want 0/0", timeout, exp_q.size());
      else pass_cnt++;
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      req    = '0;
      test_reset();
      test_rotation();
      test_single();
      test_wrap();
      test_enable();
      test_mid_reset();
      test_watchdog();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
